// File: rtl/key_debounce_bank.sv
// ---------------------------------------------------------------------------
// key_debounce_bank
//
// Multi-channel debouncer for piano keys and panel buttons. Every channel has
// its own input synchroniser, a two-state qualification FSM (IDLE / COUNT)
// and a stability counter. A change on the synchronised input is accepted
// only after it has disagreed with the current debounced level for
// DEBOUNCE_CYCLES+1 consecutive clock edges. Any bounce back to the current
// level throws the partial count away.
//
// Optional build macro:
//   DEBOUNCE_REPEAT_EN - adds a per-channel hold counter. A key held for
//                        HOLD_CYCLES after its qualified press fires an extra
//                        press_pulse, then one every REPEAT_CYCLES while held.
//                        Without the macro HOLD_CYCLES / REPEAT_CYCLES are
//                        ignored and no hold logic exists.
//
// Ports:
//   clk            system clock (100 MHz nominal)
//   rst            asynchronous, active-low reset
//   key_in         raw asynchronous key levels, 1 = pressed
//   key_out        debounced level per channel
//   press_pulse    1-cycle pulse when key_out rises (and on auto-repeat ticks)
//   release_pulse  1-cycle pulse when key_out falls
//   any_change     OR of all press/release pulses, same cycle as the pulses
// ---------------------------------------------------------------------------
module key_debounce_bank #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic              any_change
);

  // DEBOUNCE_CYCLES >= 2 guarantees at least one counter bit.
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Elaboration-time sanity check of the configuration.
  if (N_KEYS < 1 || N_KEYS > 32 || DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("key_debounce_bank: illegal parameter combination");
  end

  // -------------------------------------------------------------------------
  // Input synchronisers: stage 0 samples the pins, the last stage is the only
  // view of key_in the rest of the block ever sees.
  // -------------------------------------------------------------------------
  logic [N_KEYS-1:0] sync_pipe [SYNC_STAGES];
  logic [N_KEYS-1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_pipe[s] <= '0;
      end
    end else begin
      sync_pipe[0] <= key_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_pipe[s] <= sync_pipe[s-1];
      end
    end
  end

  assign sync = sync_pipe[SYNC_STAGES-1];

  // Per-channel level and next-cycle pulse requests, gathered as vectors so
  // the pulse outputs and any_change can be registered together below.
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] press_next;
  logic [N_KEYS-1:0] release_next;

`ifdef DEBOUNCE_REPEAT_EN
  // The hold counter is sized for the longer of the two intervals so that a
  // REPEAT_CYCLES larger than HOLD_CYCLES still fits.
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             differs;
    logic             commit;
    logic             rise_evt;
    logic             fall_evt;

    assign differs  = (sync[g] != level);
    // The qualifying edge: still disagreeing on the last count value.
    assign commit   = (state == COUNT) && differs && (cnt == CNT_LAST);
    assign rise_evt = commit &&  sync[g];
    assign fall_evt = commit && !sync[g];

    // Qualification FSM. The counter is cleared on every transition and can
    // never pass CNT_LAST because reaching it always leaves COUNT.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (differs) begin
              state <= COUNT;
              cnt   <= '0;
            end
          end
          COUNT: begin
            if (!differs) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              level <= sync[g];
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign level_q[g]      = level;
    assign release_next[g] = fall_evt;

`ifdef DEBOUNCE_REPEAT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic              repeating;
    logic              repeat_fire;

    // A pending release committing on this edge beats a repeat tick, so a
    // channel never requests press and release together.
    assign repeat_fire = level && !fall_evt &&
                         (hold_cnt == (repeating ? REP_LAST : HOLD_LAST));

    // Hold timer: restarts on the qualified rise, runs while the level stays
    // high, and is held at zero whenever the level is low or falling.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (rise_evt || fall_evt || !level) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (repeat_fire) begin
        hold_cnt  <= '0;
        repeating <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end

    assign press_next[g] = rise_evt || repeat_fire;
`else
    assign press_next[g] = rise_evt;
`endif
  end

  assign key_out = level_q;

  // Pulse outputs and their summary flag are registered in the same block so
  // any_change lines up with the pulses it summarises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_pulse   <= '0;
      release_pulse <= '0;
      any_change    <= 1'b0;
    end else begin
      press_pulse   <= press_next;
      release_pulse <= release_next;
      any_change    <= |(press_next | release_next);
    end
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_bank
//
// Self-checking bench for key_debounce_bank with N_KEYS=4, DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2 (HOLD_CYCLES=10, REPEAT_CYCLES=5 when DEBOUNCE_REPEAT_EN is
// defined). Directed scenarios check fixed expectations; a randomized run is
// checked against a behavioural model that tracks, per channel, how many
// consecutive synchronised samples have disagreed with the debounced level.
// ---------------------------------------------------------------------------
module tb_key_debounce_bank;

  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int SS   = 2;
  localparam int HOLD = 10;
  localparam int REP  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_out;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic          any_change;

  int total = 0;
  int bad   = 0;

  key_debounce_bank #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (SS),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_out      (key_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_change   (any_change)
  );

  always #5 clk = ~clk;

  // Behavioural reference model.
  logic [NK-1:0] m_pipe [SS];
  logic [NK-1:0] m_out;
  logic [NK-1:0] m_press;
  logic [NK-1:0] m_release;
  logic          m_any;
  int            m_run [NK];
  int            m_age [NK];

  task automatic model_clear();
    for (int s = 0; s < SS; s++) m_pipe[s] = '0;
    m_out = '0; m_press = '0; m_release = '0; m_any = 1'b0;
    for (int c = 0; c < NK; c++) begin
      m_run[c] = 0;
      m_age[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] seen;
    logic          was_high;
    seen = m_pipe[SS-1];
    for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = key_in;
    m_press   = '0;
    m_release = '0;
    for (int c = 0; c < NK; c++) begin
      was_high = m_out[c];
      if (seen[c] != m_out[c]) begin
        m_run[c]++;
        if (m_run[c] == DB + 1) begin
          m_out[c] = seen[c];
          m_run[c] = 0;
          m_age[c] = 0;
          if (seen[c]) m_press[c] = 1'b1;
          else         m_release[c] = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
`ifdef DEBOUNCE_REPEAT_EN
      if (was_high && m_out[c]) begin
        m_age[c]++;
        if (m_age[c] == HOLD || (m_age[c] > HOLD && (m_age[c] - HOLD) % REP == 0))
          m_press[c] = 1'b1;
      end
`else
      if (was_high && m_out[c]) m_age[c]++;
`endif
    end
    m_any = |(m_press | m_release);
  endtask

  // One clock edge: update the model from the sampled inputs, then settle.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_clear();
    else      model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [NK-1:0] level);
    rst    = 1'b0;
    key_in = level;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    key_in = 4'b1111;
    tick(); tick(); tick();
    total++;
    if ({key_out, press_pulse, release_pulse, any_change} !== 13'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=0", {key_out, press_pulse, release_pulse, any_change});
    end
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      total++;
      if (key_out !== ((e >= 7) ? 4'b1111 : 4'b0000)) begin
        bad++;
        $display("[TB] FAIL reset_requal_level edge=%0d got=%b want=%b", e, key_out, (e >= 7) ? 4'b1111 : 4'b0000);
      end
      total++;
      if (press_pulse !== ((e == 7) ? 4'b1111 : 4'b0000)) begin
        bad++;
        $display("[TB] FAIL reset_requal_press edge=%0d got=%b want=%b", e, press_pulse, (e == 7) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  task automatic test_single_step();
    do_reset(4'b0000);
    key_in[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      total++;
      if ({key_out, press_pulse, release_pulse, any_change} !==
          {((e >= 7) ? 4'b0001 : 4'b0000), ((e == 7) ? 4'b0001 : 4'b0000), 4'b0000, (e == 7)}) begin
        bad++;
        $display("[TB] FAIL step_rise edge=%0d got=%b want key_out=%0d press=%0d", e,
                 {key_out, press_pulse, release_pulse, any_change}, e >= 7, e == 7);
      end
    end
    key_in[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      total++;
      if ({key_out, press_pulse, release_pulse, any_change} !==
          {((e < 7) ? 4'b0001 : 4'b0000), 4'b0000, ((e == 7) ? 4'b0001 : 4'b0000), (e == 7)}) begin
        bad++;
        $display("[TB] FAIL step_fall edge=%0d got=%b want key_out=%0d release=%0d", e,
                 {key_out, press_pulse, release_pulse, any_change}, e < 7, e == 7);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(4'b0000);
    for (int c = 0; c < 20; c++) begin
      key_in[1] = ((c / 3) % 2 == 1);
      tick();
      total++;
      if ({key_out, press_pulse, release_pulse, any_change} !== 13'b0) begin
        bad++;
        $display("[TB] FAIL glitch_quiet cycle=%0d got=%b want=0", c, {key_out, press_pulse, release_pulse, any_change});
      end
    end
    key_in[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      total++;
      if ({key_out, press_pulse} !== {((e >= 7) ? 4'b0010 : 4'b0000), ((e == 7) ? 4'b0010 : 4'b0000)}) begin
        bad++;
        $display("[TB] FAIL glitch_hold edge=%0d got=%b want key_out1=%0d press1=%0d", e, {key_out, press_pulse}, e >= 7, e == 7);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset(4'b0000);
    key_in = 4'b1100;
    for (int e = 1; e <= 8; e++) begin
      tick();
      total++;
      if ({press_pulse, any_change} !== {((e == 7) ? 4'b1100 : 4'b0000), (e == 7)}) begin
        bad++;
        $display("[TB] FAIL simul_press edge=%0d got=%b want press=%b any=%0d", e, {press_pulse, any_change},
                 (e == 7) ? 4'b1100 : 4'b0000, e == 7);
      end
    end
    total++;
    if (key_out !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL simul_level got=%b want=1100", key_out);
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset(4'b1100);
    for (int e = 1; e <= 8; e++) tick();
    key_in = 4'b1101;
    for (int e = 1; e <= 5; e++) tick();
    total++;
    if (key_out !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL midcount_before got=%b want=1100", key_out);
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({key_out, press_pulse, release_pulse, any_change} !== 13'b0) begin
      bad++;
      $display("[TB] FAIL midcount_async_clear got=%b want=0", {key_out, press_pulse, release_pulse, any_change});
    end
    tick();
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      total++;
      if ({key_out, press_pulse} !== {((e >= 7) ? 4'b1101 : 4'b0000), ((e == 7) ? 4'b1101 : 4'b0000)}) begin
        bad++;
        $display("[TB] FAIL midcount_requal edge=%0d got=%b want level=%0d pulse=%0d", e, {key_out, press_pulse}, e >= 7, e == 7);
      end
    end
  endtask

  task automatic test_random();
    int hold_left [NK];
    do_reset(4'b0000);
    for (int c = 0; c < NK; c++) hold_left[c] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < NK; c++) begin
        if (hold_left[c] == 0) begin
          key_in[c]    = $urandom_range(0, 1) == 1;
          hold_left[c] = $urandom_range(1, 12);
        end
        hold_left[c]--;
      end
      if (cyc == 400) rst = 1'b0;
      if (cyc == 402) rst = 1'b1;
      tick();
      total++;
      if (key_out !== m_out) begin
        bad++;
        $display("[TB] FAIL rand_level cycle=%0d got=%b want=%b", cyc, key_out, m_out);
      end
      total++;
      if ({press_pulse, release_pulse, any_change} !== {m_press, m_release, m_any}) begin
        bad++;
        $display("[TB] FAIL rand_pulses cycle=%0d got=%b want=%b", cyc,
                 {press_pulse, release_pulse, any_change}, {m_press, m_release, m_any});
      end
      total++;
      if ((press_pulse & release_pulse) !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL rand_exclusive cycle=%0d got=%b want=0000", cyc, press_pulse & release_pulse);
      end
    end
  endtask

`ifdef DEBOUNCE_REPEAT_EN
  task automatic test_auto_repeat();
    logic exp;
    do_reset(4'b0000);
    key_in[0] = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    total++;
    if (press_pulse !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL repeat_first got=%b want=0001", press_pulse);
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp = (k == HOLD) || (k > HOLD && (k - HOLD) % REP == 0);
      total++;
      if (press_pulse !== {3'b000, exp}) begin
        bad++;
        $display("[TB] FAIL repeat_tick k=%0d got=%b want=%b", k, press_pulse, {3'b000, exp});
      end
    end
    key_in[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if ({key_out, press_pulse, release_pulse} !== {m_out, m_press, m_release}) begin
        bad++;
        $display("[TB] FAIL repeat_release edge=%0d got=%b want=%b", e,
                 {key_out, press_pulse, release_pulse}, {m_out, m_press, m_release});
      end
    end
    for (int e = 1; e <= 20; e++) begin
      tick();
      total++;
      if ({key_out, press_pulse} !== 8'b0) begin
        bad++;
        $display("[TB] FAIL repeat_after_release edge=%0d got=%b want=0", e, {key_out, press_pulse});
      end
    end
  endtask
`endif

  initial begin
    model_clear();
    $display("[TB] starting key_debounce_bank bench");
    test_reset();
    test_single_step();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
`ifdef DEBOUNCE_REPEAT_EN
    test_auto_repeat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
